uart_rx_deserializer: RTL and testbench

- Receive front-end for the Amber UART. Sits between the pad-side serial input and the UART's receive FIFO.
- Synchronises the raw receive line, detects start bits, samples each bit at its centre and assembles 8N1 frames into bytes.
- Hands each byte to the RX FIFO through a valid/ready handshake and reports framing and overrun errors for the RSR register.

---
 rtl/uart_rx_deserializer.sv | 182 ++++++++++++++++++
 tb/tb_uart_rx_deserializer.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deserializer.sv
// Amber UART receive front-end: synchronises rxd, samples bit centres, assembles 8N1 bytes.
// Define AMBER_UART_RX_PARITY_EN for 8E1 frames with an o_parity_err pulse.
module uart_rx_deserializer #(
    parameter int DIVISOR = 174,
    parameter int CNT_W   = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_uart_rxd,
    input  logic       i_rx_ready,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    output logic       o_frame_err,
    output logic       o_overrun,
`ifdef AMBER_UART_RX_PARITY_EN
    output logic       o_parity_err,
`endif
    output logic       o_busy
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;
    localparam logic [2:0] BREAK  = 3'd5;

    localparam logic [CNT_W-1:0] DIV_FULL = CNT_W'(DIVISOR);
    localparam logic [CNT_W-1:0] DIV_HALF = CNT_W'(DIVISOR / 2);

    logic             sync1_q, rxd_s_q, prev_q;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
    logic             tick;
`ifdef AMBER_UART_RX_PARITY_EN
    logic             par_q, par_d;
    logic             par_err_q, par_err_d;
`endif

    assign tick = (cnt_q == CNT_W'(1));

    always_comb begin
        state_d     = state_q;
        cnt_d       = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
`ifdef AMBER_UART_RX_PARITY_EN
        par_d       = par_q;
        par_err_d   = 1'b0;
`endif
        if (valid_q && i_rx_ready) begin
            valid_d = 1'b0;
        end
        case (state_q)
            IDLE: begin
                if (prev_q && !rxd_s_q) begin
                    cnt_d   = DIV_HALF;
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    if (!rxd_s_q) begin
                        cnt_d     = DIV_FULL;
                        bit_cnt_d = 3'd0;
                        state_d   = DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d   = {rxd_s_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    cnt_d     = DIV_FULL;
                    if (bit_cnt_q == 3'd7) begin
`ifdef AMBER_UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef AMBER_UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    par_d   = rxd_s_q;
                    cnt_d   = DIV_FULL;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (tick) begin
`ifdef AMBER_UART_RX_PARITY_EN
                    par_err_d = ^{shift_q, par_q};
`endif
                    if (rxd_s_q) begin
                        state_d = IDLE;
                        // A consumer draining this cycle frees the holding register
                        if (!valid_q || i_rx_ready) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rxd_s_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync1_q     <= 1'b1;
            rxd_s_q     <= 1'b1;
            prev_q      <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'd0;
            data_q      <= 8'd0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync1_q     <= i_uart_rxd;
            rxd_s_q     <= sync1_q;
            prev_q      <= rxd_s_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef AMBER_UART_RX_PARITY_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            par_q     <= 1'b0;
            par_err_q <= 1'b0;
        end else begin
            par_q     <= par_d;
            par_err_q <= par_err_d;
        end
    end

    assign o_parity_err = par_err_q;
`endif

    assign o_rx_data   = data_q;
    assign o_rx_valid  = valid_q;
    assign o_frame_err = frame_err_q;
    assign o_overrun   = overrun_q;
    assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Bench for uart_rx_deserializer: scenario tasks plus randomized frames
// checked against a byte-queue model of the serial line.
module tb_uart_rx_deserializer;

    localparam int DIV = 8;
    localparam int LAT = 2 + DIV / 2 + 9 * DIV + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rxd = 1'b1;
    logic       ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;
`ifdef AMBER_UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int checks = 0;
    int errors = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    uart_rx_deserializer #(.DIVISOR(DIV), .CNT_W(16)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_uart_rxd  (rxd),
        .i_rx_ready  (ready),
        .o_rx_data   (rx_data),
        .o_rx_valid  (rx_valid),
        .o_frame_err (frame_err),
        .o_overrun   (overrun),
`ifdef AMBER_UART_RX_PARITY_EN
        .o_parity_err(parity_err),
`endif
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    // Observer: bytes consumed by the FIFO side and error pulses
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid && ready) got_q.push_back(rx_data);
            if (frame_err) fe_cnt++;
            if (overrun) ov_cnt++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        cyc(DIV);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            cyc(DIV);
        end
        rxd = stop;
        cyc(DIV);
        rxd = 1'b1;
    endtask

    task automatic check_queues(input string name);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s: got %0d bytes, expected %0d", name, got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL %s[%0d]: got %h, expected %h", name, i, got_q[i], exp_q[i]);
                end
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        cyc(3);
        checks++;
        if ({rx_data, rx_valid, frame_err, overrun, busy} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs: got %h, expected 000",
                     {rx_data, rx_valid, frame_err, overrun, busy});
        end
        rst = 1'b0;
        cyc(4);
        checks++;
        if (busy !== 1'b0 || rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: busy=%b valid=%b, expected 0 0", busy, rx_valid);
        end
    endtask

    task automatic test_latency;
        int n;
        int fe0;
        int ov0;
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        ready = 1'b1;
        n = 0;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                while (rx_valid !== 1'b1 && n < 300) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
            end
        join_any
        checks++;
        if (n != LAT) begin
            errors++;
            $display("FAIL latency: valid after %0d cycles, expected %0d", n, LAT);
        end
        checks++;
        if (rx_data !== 8'hA5) begin
            errors++;
            $display("FAIL latency_data: got %h, expected a5", rx_data);
        end
        cyc(1);
        checks++;
        if (rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL valid_one_cycle: valid=%b, expected 0", rx_valid);
        end
        wait fork;
        cyc(DIV);
        checks++;
        if (fe_cnt != fe0 || ov_cnt != ov0) begin
            errors++;
            $display("FAIL latency_errs: fe=%0d ov=%0d, expected 0 0", fe_cnt - fe0, ov_cnt - ov0);
        end
        got_q.delete();
    endtask

    task automatic test_glitch;
        int busy_n;
        busy_n = 0;
        rxd = 1'b0;
        cyc(3);
        rxd = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (busy) busy_n++;
            cyc(1);
        end
        checks++;
        if (busy_n == 0 || busy_n >= DIV) begin
            errors++;
            $display("FAIL glitch_busy: busy %0d cycles, expected 1..%0d", busy_n, DIV - 1);
        end
        checks++;
        if (got_q.size() != 0 || rx_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL glitch_idle: bytes=%0d valid=%b busy=%b, expected 0 0 0",
                     got_q.size(), rx_valid, busy);
        end
    endtask

    task automatic test_frame_error;
        int fe0;
        int not_busy;
        fe0 = fe_cnt;
        not_busy = 0;
        ready = 1'b1;
        send_frame(8'h3C, 1'b0);
        rxd = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!busy) not_busy++;
            cyc(1);
        end
        rxd = 1'b1;
        cyc(2 * DIV);
        checks++;
        if (not_busy != 0) begin
            errors++;
            $display("FAIL break_busy: idle %0d cycles while low, expected 0", not_busy);
        end
        checks++;
        if (fe_cnt - fe0 != 1) begin
            errors++;
            $display("FAIL frame_err_pulses: got %0d, expected 1", fe_cnt - fe0);
        end
        send_frame(8'h11, 1'b1);
        cyc(DIV);
        exp_q.push_back(8'h11);
        check_queues("frame_err_recover");
    endtask

    task automatic test_overrun;
        int ov0;
        ov0 = ov_cnt;
        ready = 1'b0;
        send_frame(8'h01, 1'b1);
        cyc(DIV);
        send_frame(8'h02, 1'b1);
        cyc(DIV);
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h01) begin
            errors++;
            $display("FAIL overrun_hold: valid=%b data=%h, expected 1 01", rx_valid, rx_data);
        end
        checks++;
        if (ov_cnt - ov0 != 1) begin
            errors++;
            $display("FAIL overrun_pulses: got %0d, expected 1", ov_cnt - ov0);
        end
        ready = 1'b1;
        cyc(1);
        checks++;
        if (rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL overrun_drain: valid=%b, expected 0", rx_valid);
        end
        exp_q.push_back(8'h01);
        check_queues("overrun_bytes");
    endtask

    task automatic test_back_to_back;
        int fe0;
        int ov0;
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        ready = 1'b1;
        send_frame(8'h55, 1'b1);
        send_frame(8'hAA, 1'b1);
        cyc(DIV);
        exp_q.push_back(8'h55);
        exp_q.push_back(8'hAA);
        check_queues("back_to_back");
        checks++;
        if (fe_cnt != fe0 || ov_cnt != ov0) begin
            errors++;
            $display("FAIL b2b_errs: fe=%0d ov=%0d, expected 0 0", fe_cnt - fe0, ov_cnt - ov0);
        end
    endtask

    task automatic test_reset_mid;
        ready = 1'b0;
        send_frame(8'h81, 1'b1);
        cyc(DIV);
        rxd = 1'b0;
        cyc(DIV);
        rxd = 1'b1;
        cyc(3 * DIV);
        rst = 1'b1;
        #1;
        checks++;
        if ({rx_data, rx_valid, frame_err, overrun, busy} !== 12'h000) begin
            errors++;
            $display("FAIL reset_mid: got %h, expected 000",
                     {rx_data, rx_valid, frame_err, overrun, busy});
        end
        cyc(3);
        rst = 1'b0;
        got_q.delete();
        ready = 1'b1;
        cyc(6 * DIV);
        send_frame(8'h7E, 1'b1);
        cyc(DIV);
        exp_q.push_back(8'h7E);
        check_queues("after_reset");
    endtask

    task automatic test_random;
        logic [7:0] b;
        int fe0;
        fe0 = fe_cnt;
        ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            send_frame(b, 1'b1);
            cyc($urandom_range(0, 3 * DIV));
        end
        cyc(DIV);
        check_queues("random");
        checks++;
        if (fe_cnt != fe0) begin
            errors++;
            $display("FAIL random_errs: fe=%0d, expected 0", fe_cnt - fe0);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_frame_error();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
